// File: rtl/vector_reverser_stream.sv
// Streaming bit/byte reorder unit: output register plus a 1-entry skid buffer.
// Optional transfer counter on xfer_cnt when VREV_STATS_EN is defined.
module vector_reverser_stream #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_mode
`ifdef VREV_STATS_EN
   ,
   output logic [15:0]      xfer_cnt
`endif
);

   localparam int NBYTES = WIDTH / 8;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   function automatic logic [WIDTH-1:0] transform(input logic [WIDTH-1:0] d,
                                                   input logic [1:0]       m);
      logic [WIDTH-1:0] r;
      r = d;
      case (m)
         2'b01: begin
            for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
         end
         2'b10: begin
            for (int k = 0; k < NBYTES; k++) r[8*k +: 8] = d[8*(NBYTES-1-k) +: 8];
         end
         2'b11: begin
            for (int k = 0; k < NBYTES; k++)
               for (int j = 0; j < 8; j++) r[8*k+j] = d[8*k+7-j];
         end
         default: r = d;
      endcase
      return r;
   endfunction

   state_t           state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [1:0]       out_mode_q, out_mode_d;
   logic             skd_valid_q, skd_valid_d;
   logic [WIDTH-1:0] skd_data_q, skd_data_d;
   logic [1:0]       skd_mode_q, skd_mode_d;
   logic             in_ready_q, in_ready_d;
   logic             accept, drain;
   logic [WIDTH-1:0] in_xform;

   assign accept   = in_valid && in_ready_q;
   assign drain    = out_valid_q && out_ready;
   assign in_xform = transform(in_data, in_mode);

   always_comb begin
      state_d     = state_q;
      out_data_d  = out_data_q;
      out_mode_d  = out_mode_q;
      skd_valid_d = skd_valid_q;
      skd_data_d  = skd_data_q;
      skd_mode_d  = skd_mode_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               out_data_d = in_xform;
               out_mode_d = in_mode;
               state_d    = ONE;
            end
         end
         ONE: begin
            if (accept && drain) begin
               out_data_d = in_xform;
               out_mode_d = in_mode;
            end else if (accept) begin
               skd_data_d  = in_xform;
               skd_mode_d  = in_mode;
               skd_valid_d = 1'b1;
               state_d     = FULL;
            end else if (drain) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // in_ready is low here, so the only possible move is a drain
            if (drain) begin
               out_data_d  = skd_data_q;
               out_mode_d  = skd_mode_q;
               skd_valid_d = 1'b0;
               state_d     = ONE;
            end
         end
         default: begin
            state_d     = EMPTY;
            skd_valid_d = 1'b0;
         end
      endcase
      out_valid_d = (state_d != EMPTY);
      in_ready_d  = !skd_valid_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_mode_q  <= 2'b00;
         skd_valid_q <= 1'b0;
         skd_data_q  <= '0;
         skd_mode_q  <= 2'b00;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_mode_q  <= out_mode_d;
         skd_valid_q <= skd_valid_d;
         skd_data_q  <= skd_data_d;
         skd_mode_q  <= skd_mode_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_mode  = out_mode_q;

`ifdef VREV_STATS_EN
   logic [15:0] xfer_cnt_q, xfer_cnt_d;

   always_comb begin
      xfer_cnt_d = xfer_cnt_q;
      if (drain) xfer_cnt_d = xfer_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) xfer_cnt_q <= 16'd0;
      else        xfer_cnt_q <= xfer_cnt_d;
   end

   assign xfer_cnt = xfer_cnt_q;
`endif

endmodule
